step_period_meter: RTL

Measures the interval, in `clk` cycles, between consecutive rising edges of an external step pulse train. It is the inverse of the rate generator: that block turns a ratio into a pulse rate, and this block turns a pulse rate back into a period word. It sits on the feedback/monitor side of each stepper channel. Encoder or step-echo inputs enter here, and the resulting period is read by the host register interface or a speed loop.

---
 rtl/qs_pkg.sv | 15 +
 rtl/step_period_meter_if.sv | 29 ++
 rtl/edge_detector.sv | 34 +++
 rtl/step_period_meter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/qs_pkg.sv
// Shared definitions for the step-channel monitor blocks: FSM state encoding
// and default widths.
package qs_pkg;

    localparam int DEFAULT_COUNT_BITS  = 32;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Measurement FSM states, also exported on the debug state output.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

endpackage : qs_pkg

// File: rtl/step_period_meter_if.sv
// Control/result bundle of the step period meter.
//
// Handshake: there is no backpressure. period_valid is a one-cycle strobe
// raised by the meter (slave) in the cycle period carries a new measurement;
// the consumer (master) must sample it in that cycle. enable, step_in and
// timeout_limit are plain levels driven by the master.
interface step_period_meter_if
    import qs_pkg::*;
#(
    parameter int COUNT_BITS = DEFAULT_COUNT_BITS
);
    logic                  enable;
    logic                  step_in;
    logic [COUNT_BITS-1:0] timeout_limit;
    logic [COUNT_BITS-1:0] period;
    logic                  period_valid;
    logic                  timeout;
    state_t                dbg_state;

    modport master (
        output enable, step_in, timeout_limit,
        input  period, period_valid, timeout, dbg_state
    );

    modport slave (
        input  enable, step_in, timeout_limit,
        output period, period_valid, timeout, dbg_state
    );
endinterface : step_period_meter_if

// File: rtl/edge_detector.sv
// Synchronizes an asynchronous input and produces a registered one-cycle
// strobe on each synchronized rising edge.
module edge_detector
    import qs_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic edge_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_q;

    // Synchronizer chain, history flop and registered edge strobe; these run
    // regardless of the measurement state so a level already high at enable
    // never looks like a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

    assign edge_o = edge_q;

endmodule : edge_detector

// File: rtl/step_period_meter.sv
// Measures the number of clk cycles between consecutive synchronized rising
// edges of step_in. A silent input is declared stopped after timeout_limit
// cycles (or on counter saturation), which forces period to 0.
module step_period_meter
    import qs_pkg::*;
#(
    parameter int COUNT_BITS  = DEFAULT_COUNT_BITS,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    step_period_meter_if.slave  bus
);
    localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [COUNT_BITS-1:0] CNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [COUNT_BITS-1:0] period_q, period_d;
    logic                  valid_q, valid_d;
    logic                  timeout_q, timeout_d;

    logic                  edge_s;
    logic                  enable_s;
    logic [COUNT_BITS-1:0] limit_s;
    logic                  limit_hit;

    assign enable_s = bus.enable;
    assign limit_s  = bus.timeout_limit;

    edge_detector #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.step_in),
        .edge_o (edge_s)
    );

    // A zero limit disables the programmable timeout; saturation always ends
    // the measurement so the counter can never wrap.
    assign limit_hit = ((limit_s != '0) && (cnt_q == limit_s)) || (cnt_q == CNT_MAX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (!enable_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       state_d = WAIT_FIRST;
                WAIT_FIRST: if (edge_s) state_d = MEASURE;
                MEASURE:    if (!edge_s && limit_hit) state_d = WAIT_FIRST;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Datapath next values; an edge takes priority over a coincident timeout.
    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!enable_s) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
                WAIT_FIRST: begin
                    cnt_d = '0;
                    if (edge_s) begin
                        cnt_d     = CNT_ONE;
                        timeout_d = 1'b0;
                    end
                end
                MEASURE: begin
                    if (edge_s) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                    end else if (limit_hit) begin
                        period_d  = '0;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.timeout      = timeout_q;
    assign bus.dbg_state    = state_q;

endmodule : step_period_meter
